// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared gate state encoding, defaults and zone classes
package parking_pkg;

  typedef logic [2:0] gate_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_OPEN   = 3'd2;
  localparam logic [2:0] ST_REPORT = 3'd3;
  localparam logic [2:0] ST_REJECT = 3'd4;
  localparam logic [2:0] ST_CLEAR  = 3'd5;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_OPEN_TIMEOUT    = 64;

  localparam logic ZONE_UNI  = 1'b1;
  localparam logic ZONE_FREE = 1'b0;

  function automatic logic zone_has_room(input logic is_uni, input logic uni_room,
                                         input logic free_room);
    if (is_uni == ZONE_UNI) return uni_room;
    else if (is_uni == ZONE_FREE) return free_room;
    else return 1'b0;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - 2-flop synchroniser plus counting debouncer with rise pulse
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample matching the current level restarts the run.
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - entry/exit barrier FSMs issuing one event per passing car
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int OPEN_TIMEOUT    = DEFAULT_OPEN_TIMEOUT,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic entry_arrive_raw,
  input  logic entry_pass_raw,
  input  logic entry_is_uni,
  input  logic exit_arrive_raw,
  input  logic exit_pass_raw,
  input  logic exit_is_uni,
  input  logic uni_is_vacated_space,
  input  logic free_is_vacated_space,
  output logic entry_barrier_open,
  output logic exit_barrier_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_rejected
);

  logic ent_arrive_lvl, ent_arrive_rise, ent_pass_lvl, ent_pass_rise;
  logic ext_arrive_lvl, ext_arrive_rise, ext_pass_lvl, ext_pass_rise;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ent_arrive (
    .clk(clk), .rst_n(rst_n), .raw(entry_arrive_raw), .level(ent_arrive_lvl), .rise(ent_arrive_rise));
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ent_pass (
    .clk(clk), .rst_n(rst_n), .raw(entry_pass_raw), .level(ent_pass_lvl), .rise(ent_pass_rise));
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ext_arrive (
    .clk(clk), .rst_n(rst_n), .raw(exit_arrive_raw), .level(ext_arrive_lvl), .rise(ext_arrive_rise));
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ext_pass (
    .clk(clk), .rst_n(rst_n), .raw(exit_pass_raw), .level(ext_pass_lvl), .rise(ext_pass_rise));

  gate_state_t      ent_state, ext_state;
  logic [CNT_W-1:0] ent_tcnt, ext_tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_state          <= ST_IDLE;
      ent_tcnt           <= '0;
      is_uni_car_entered <= 1'b0;
    end else begin
      case (ent_state)
        ST_IDLE:   if (ent_arrive_rise) ent_state <= ST_CHECK;
        ST_CHECK: begin
          // Room is judged only here; a later full flag does not revoke admission.
          is_uni_car_entered <= entry_is_uni;
          ent_tcnt           <= '0;
          ent_state <= zone_has_room(entry_is_uni, uni_is_vacated_space, free_is_vacated_space)
                       ? ST_OPEN : ST_REJECT;
        end
        ST_OPEN: begin
          if (ent_pass_rise) ent_state <= ST_REPORT;
          else if (ent_tcnt == CNT_W'(OPEN_TIMEOUT - 1)) ent_state <= ST_CLEAR;
          else ent_tcnt <= ent_tcnt + 1'b1;
        end
        ST_REPORT, ST_REJECT: ent_state <= ST_CLEAR;
        ST_CLEAR:  if (!ent_arrive_lvl && !ent_pass_lvl) ent_state <= ST_IDLE;
        default:   ent_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_state         <= ST_IDLE;
      ext_tcnt          <= '0;
      is_uni_car_exited <= 1'b0;
    end else begin
      case (ext_state)
        ST_IDLE: begin
          if (ext_arrive_rise) begin
            is_uni_car_exited <= exit_is_uni;
            ext_tcnt          <= '0;
            ext_state         <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (ext_pass_rise) ext_state <= ST_REPORT;
          else if (ext_tcnt == CNT_W'(OPEN_TIMEOUT - 1)) ext_state <= ST_CLEAR;
          else ext_tcnt <= ext_tcnt + 1'b1;
        end
        ST_REPORT: ext_state <= ST_CLEAR;
        ST_CLEAR:  if (!ext_arrive_lvl && !ext_pass_lvl) ext_state <= ST_IDLE;
        default:   ext_state <= ST_IDLE;
      endcase
    end
  end

  assign entry_barrier_open = (ent_state == ST_OPEN);
  assign car_entered        = (ent_state == ST_REPORT);
  assign entry_rejected     = (ent_state == ST_REJECT);
  assign exit_barrier_open  = (ext_state == ST_OPEN);
  assign car_exited         = (ext_state == ST_REPORT);

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - scoreboard bench for parking_gate_controller
module tb_parking_gate_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic entry_arrive_raw, entry_pass_raw, entry_is_uni;
  logic exit_arrive_raw, exit_pass_raw, exit_is_uni;
  logic uni_is_vacated_space, free_is_vacated_space;
  logic entry_barrier_open, exit_barrier_open;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, entry_rejected;

  always #5 clk = ~clk;

  parking_gate_controller #(.DEBOUNCE_CYCLES(4), .OPEN_TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_arrive_raw(entry_arrive_raw), .entry_pass_raw(entry_pass_raw), .entry_is_uni(entry_is_uni),
    .exit_arrive_raw(exit_arrive_raw), .exit_pass_raw(exit_pass_raw), .exit_is_uni(exit_is_uni),
    .uni_is_vacated_space(uni_is_vacated_space), .free_is_vacated_space(free_is_vacated_space),
    .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_rejected(entry_rejected));

  int   n_checks = 0;
  int   n_fail   = 0;
  logic entry_q[$];
  logic exit_q[$];
  int   ent_pulses = 0, ext_pulses = 0, rej_pulses = 0, ent_bar_cycles = 0;
  int   cycle = 0, last_ent_cycle = -1, last_ext_cycle = -2;
  logic prev_ent = 1'b0, prev_ext = 1'b0;
  logic exp_ent, exp_ext;

  always @(posedge clk) cycle++;

  // Event monitor: every pulse must match an expected car pushed by a test.
  always @(negedge clk) begin
    if (rst_n) begin
      if (entry_barrier_open) ent_bar_cycles++;
      if (entry_rejected) rej_pulses++;
      if (car_entered) begin
        ent_pulses++;
        last_ent_cycle = cycle;
        n_checks++;
        if (entry_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_car_entered: got a pulse, required none at cycle %0d", cycle);
        end else begin
          exp_ent = entry_q.pop_front();
          if (is_uni_car_entered !== exp_ent) begin
            n_fail++;
            $display("FAIL entry_class: got %b, required %b", is_uni_car_entered, exp_ent);
          end
        end
        n_checks++;
        if (prev_ent) begin
          n_fail++;
          $display("FAIL car_entered_width: got high 2+ cycles, required 1");
        end
      end
      if (car_exited) begin
        ext_pulses++;
        last_ext_cycle = cycle;
        n_checks++;
        if (exit_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_car_exited: got a pulse, required none at cycle %0d", cycle);
        end else begin
          exp_ext = exit_q.pop_front();
          if (is_uni_car_exited !== exp_ext) begin
            n_fail++;
            $display("FAIL exit_class: got %b, required %b", is_uni_car_exited, exp_ext);
          end
        end
        n_checks++;
        if (prev_ext) begin
          n_fail++;
          $display("FAIL car_exited_width: got high 2+ cycles, required 1");
        end
      end
    end
    prev_ent = car_entered;
    prev_ext = car_exited;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_open(input bit lane, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((lane ? exit_barrier_open : entry_barrier_open) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_entry(input logic cls, input string tag);
    bit ok;
    entry_is_uni = cls;
    entry_q.push_back(cls);
    entry_arrive_raw = 1'b1;
    tick(10);
    entry_arrive_raw = 1'b0;
    wait_open(1'b0, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_open: got barrier closed after 40 cycles, required open", tag);
    end
    entry_pass_raw = 1'b1;
    tick(10);
    entry_pass_raw = 1'b0;
    tick(20);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    entry_arrive_raw = 0; entry_pass_raw = 0; entry_is_uni = 0;
    exit_arrive_raw = 0; exit_pass_raw = 0; exit_is_uni = 0;
    uni_is_vacated_space = 1; free_is_vacated_space = 1;
    tick(3);
    n_checks++;
    if ({entry_barrier_open, exit_barrier_open} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_barriers: got %b, required 00", {entry_barrier_open, exit_barrier_open});
    end
    n_checks++;
    if ({car_entered, car_exited, entry_rejected, is_uni_car_entered, is_uni_car_exited} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_events: got %b, required 00000",
               {car_entered, car_exited, entry_rejected, is_uni_car_entered, is_uni_car_exited});
    end
    rst_n = 1'b1;
    tick(3);
    n_checks++;
    if ({entry_barrier_open, exit_barrier_open, car_entered, car_exited, entry_rejected} !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, required 00000",
               {entry_barrier_open, exit_barrier_open, car_entered, car_exited, entry_rejected});
    end
  endtask

  task automatic test_uni_entry;
    int e0;
    e0 = ent_pulses;
    uni_is_vacated_space = 1'b1;
    run_entry(1'b1, "uni_entry");
    n_checks++;
    if (ent_pulses - e0 != 1) begin
      n_fail++;
      $display("FAIL uni_entry_count: got %0d pulses, required 1", ent_pulses - e0);
    end
    n_checks++;
    if (is_uni_car_entered !== 1'b1) begin
      n_fail++;
      $display("FAIL uni_entry_class_hold: got %b, required 1", is_uni_car_entered);
    end
    n_checks++;
    if (entry_barrier_open !== 1'b0) begin
      n_fail++;
      $display("FAIL uni_entry_closed: got %b, required 0", entry_barrier_open);
    end
  endtask

  task automatic test_free_full;
    int e0, r0, b0;
    e0 = ent_pulses; r0 = rej_pulses; b0 = ent_bar_cycles;
    free_is_vacated_space = 1'b0;
    entry_is_uni = 1'b0;
    entry_arrive_raw = 1'b1;
    tick(10);
    entry_arrive_raw = 1'b0;
    tick(20);
    n_checks++;
    if (rej_pulses - r0 != 1) begin
      n_fail++;
      $display("FAIL free_full_reject: got %0d rejects, required 1", rej_pulses - r0);
    end
    n_checks++;
    if (ent_bar_cycles - b0 != 0) begin
      n_fail++;
      $display("FAIL free_full_barrier: got %0d open cycles, required 0", ent_bar_cycles - b0);
    end
    n_checks++;
    if (ent_pulses - e0 != 0) begin
      n_fail++;
      $display("FAIL free_full_entered: got %0d pulses, required 0", ent_pulses - e0);
    end
    free_is_vacated_space = 1'b1;
  endtask

  task automatic test_debounce;
    int e0, r0, b0;
    logic cls0;
    e0 = ent_pulses; r0 = rej_pulses; b0 = ent_bar_cycles; cls0 = is_uni_car_entered;
    entry_is_uni = 1'b1;
    repeat (5) begin
      entry_arrive_raw = 1'b1;
      tick(2);
      entry_arrive_raw = 1'b0;
      tick(2);
    end
    tick(12);
    n_checks++;
    if ((ent_bar_cycles - b0) + (rej_pulses - r0) + (ent_pulses - e0) != 0) begin
      n_fail++;
      $display("FAIL debounce_activity: got %0d barrier/%0d reject/%0d event, required all 0",
               ent_bar_cycles - b0, rej_pulses - r0, ent_pulses - e0);
    end
    n_checks++;
    if (is_uni_car_entered !== cls0) begin
      n_fail++;
      $display("FAIL debounce_class: got %b, required %b", is_uni_car_entered, cls0);
    end
  endtask

  task automatic test_timeout;
    int e0, b0;
    e0 = ent_pulses; b0 = ent_bar_cycles;
    entry_is_uni = 1'b1;
    entry_arrive_raw = 1'b1;
    tick(10);
    entry_arrive_raw = 1'b0;
    tick(120);
    n_checks++;
    if (ent_bar_cycles - b0 != 64) begin
      n_fail++;
      $display("FAIL timeout_open_cycles: got %0d, required 64", ent_bar_cycles - b0);
    end
    n_checks++;
    if (ent_pulses - e0 != 0) begin
      n_fail++;
      $display("FAIL timeout_entered: got %0d pulses, required 0", ent_pulses - e0);
    end
    n_checks++;
    if (entry_barrier_open !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_closed: got %b, required 0", entry_barrier_open);
    end
  endtask

  task automatic test_concurrent;
    int e0, x0;
    bit ok_e, ok_x;
    e0 = ent_pulses; x0 = ext_pulses;
    entry_is_uni = 1'b0; exit_is_uni = 1'b1;
    free_is_vacated_space = 1'b1;
    entry_q.push_back(1'b0);
    exit_q.push_back(1'b1);
    entry_arrive_raw = 1'b1; exit_arrive_raw = 1'b1;
    tick(10);
    entry_arrive_raw = 1'b0; exit_arrive_raw = 1'b0;
    exit_is_uni = 1'b0;
    wait_open(1'b0, 40, ok_e);
    wait_open(1'b1, 40, ok_x);
    n_checks++;
    if (!(ok_e && ok_x)) begin
      n_fail++;
      $display("FAIL concurrent_open: got entry %b exit %b, required both 1", ok_e, ok_x);
    end
    entry_pass_raw = 1'b1; exit_pass_raw = 1'b1;
    tick(10);
    entry_pass_raw = 1'b0; exit_pass_raw = 1'b0;
    tick(20);
    n_checks++;
    if (ent_pulses - e0 != 1 || ext_pulses - x0 != 1) begin
      n_fail++;
      $display("FAIL concurrent_count: got entry %0d exit %0d, required 1 and 1",
               ent_pulses - e0, ext_pulses - x0);
    end
    n_checks++;
    if (last_ent_cycle != last_ext_cycle) begin
      n_fail++;
      $display("FAIL concurrent_same_cycle: got entry @%0d exit @%0d, required equal",
               last_ent_cycle, last_ext_cycle);
    end
    n_checks++;
    if (is_uni_car_exited !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_class_hold: got %b, required 1", is_uni_car_exited);
    end
  endtask

  task automatic test_reset_mid_open;
    int e0;
    bit ok;
    e0 = ent_pulses;
    entry_is_uni = 1'b1;
    entry_arrive_raw = 1'b1;
    wait_open(1'b0, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_mid_open_reach: got barrier closed, required open");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({entry_barrier_open, car_entered} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_open_drop: got %b, required 00", {entry_barrier_open, car_entered});
    end
    entry_arrive_raw = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    n_checks++;
    if (ent_pulses - e0 != 0) begin
      n_fail++;
      $display("FAIL reset_mid_open_pulse: got %0d pulses, required 0", ent_pulses - e0);
    end
    run_entry(1'b1, "after_reset");
    n_checks++;
    if (ent_pulses - e0 != 1) begin
      n_fail++;
      $display("FAIL after_reset_entry: got %0d pulses, required 1", ent_pulses - e0);
    end
  endtask

  initial begin
    test_reset();
    test_uni_entry();
    test_free_full();
    test_debounce();
    test_timeout();
    test_concurrent();
    test_reset_mid_open();
    n_checks++;
    if (entry_q.size() != 0 || exit_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d entry and %0d exit outstanding, required 0",
               entry_q.size(), exit_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "bench time limit");
  end

endmodule
